// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop at a programmable bit rate.
// Define UART_TX_TWO_STOP_EN to stretch the stop phase to two bit periods.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int SEL_WIDTH      = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_WIDTH-1:0]     i_p_data,
  input  logic                      i_data_valid,
  input  logic                      i_par_en,
  input  logic                      i_par_typ,
  input  logic [PRESCALE_WIDTH-1:0] i_clks_per_bit,
  output logic [SEL_WIDTH-1:0]      o_sel,
  output logic                      o_ser_data,
  output logic                      o_parity_bit,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } state_t;

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic [PRESCALE_WIDTH-1:0] last_cnt;
  logic [BW-1:0]             bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic                      par_en_q;
  logic                      bit_end;

  assign bit_end    = (presc_cnt == last_cnt);
  assign o_sel      = SEL_WIDTH'(state);
  assign o_ser_data = shift_reg[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      presc_cnt    <= '0;
      last_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_en_q     <= 1'b0;
      o_parity_bit <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE) begin
        if (i_data_valid) begin
          shift_reg    <= i_p_data;
          par_en_q     <= i_par_en;
          o_parity_bit <= (^i_p_data) ^ i_par_typ;
          // Prescale stored as terminal count; a setting of 0 behaves as 1
          last_cnt     <= (i_clks_per_bit == '0) ? '0 : i_clks_per_bit - 1'b1;
          presc_cnt    <= '0;
          bit_cnt      <= '0;
          state        <= START;
          o_busy       <= 1'b1;
        end
      end else if (!bit_end) begin
        presc_cnt <= presc_cnt + 1'b1;
      end else begin
        presc_cnt <= '0;
        case (state)
          START: state <= DATA;
          DATA: begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: state <= STOP;
          STOP: begin
`ifdef UART_TX_TWO_STOP_EN
            // bit_cnt is free after DATA; reuse it to count the two stop bits
            if (bit_cnt == '0) begin
              bit_cnt <= BW'(1);
            end else begin
              bit_cnt <= '0;
              state   <= IDLE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end
`else
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl; per-cycle expected output vectors are queued when a frame is launched.
module tb_uart_tx_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_p_data = 8'h00;
  logic       i_data_valid = 1'b0;
  logic       i_par_en = 1'b0;
  logic       i_par_typ = 1'b0;
  logic [15:0] i_clks_per_bit = 16'd1;
  logic [2:0] o_sel;
  logic       o_ser_data;
  logic       o_parity_bit;
  logic       o_busy;
  logic       o_done;

  int n_asserts = 0;
  int n_fail    = 0;
  logic last_par = 1'b0;
  logic [6:0] exp_q[$];

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  uart_tx_ctrl dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_p_data       (i_p_data),
    .i_data_valid   (i_data_valid),
    .i_par_en       (i_par_en),
    .i_par_typ      (i_par_typ),
    .i_clks_per_bit (i_clks_per_bit),
    .o_sel          (o_sel),
    .o_ser_data     (o_ser_data),
    .o_parity_bit   (o_parity_bit),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [6:0] observed();
    return {o_sel, o_ser_data, o_parity_bit, o_busy, o_done};
  endfunction

  task automatic check_vec(input string tag, input int cyc, input logic [6:0] exp);
    logic [6:0] obs;
    obs = observed();
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got sel/ser/par/busy/done=%b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Builds the cycle-by-cycle expectation for one frame plus its done cycle.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int clks);
    int n;
    logic p;
    logic [7:0] sh;
    n = (clks == 0) ? 1 : clks;
    p = (^d) ^ pt;
    for (int c = 0; c < n; c++) exp_q.push_back({3'b001, d[0], p, 1'b1, 1'b0});
    for (int b = 0; b < 8; b++) begin
      sh = d >> b;
      for (int c = 0; c < n; c++) exp_q.push_back({3'b010, sh[0], p, 1'b1, 1'b0});
    end
    if (pe) for (int c = 0; c < n; c++) exp_q.push_back({3'b011, 1'b0, p, 1'b1, 1'b0});
    for (int c = 0; c < n * STOP_BITS; c++) exp_q.push_back({3'b100, 1'b0, p, 1'b1, 1'b0});
    exp_q.push_back({3'b000, 1'b0, p, 1'b0, 1'b1});
    last_par = p;
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or of abort_at).
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                           input int clks, input int inj_at, input int abort_at);
    int k;
    i_p_data = d; i_par_en = pe; i_par_typ = pt; i_clks_per_bit = 16'(clks);
    i_data_valid = 1'b1;
    push_frame(d, pe, pt, clks);
    @(posedge i_clk);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge i_clk);
      k++;
      if (k == 1) i_data_valid = 1'b0;
      if (abort_at != 0 && k == abort_at) begin
        i_rst = 1'b1;
        #1;
        check_vec({tag, "_abort"}, k, 7'b0);
        exp_q.delete();
        last_par = 1'b0;
      end else begin
        check_vec(tag, k, exp_q.pop_front());
        if (inj_at != 0 && k == inj_at) begin
          i_p_data = 8'h3C; i_data_valid = 1'b1;
          i_par_en = ~pe; i_par_typ = ~pt; i_clks_per_bit = 16'd7;
        end else if (inj_at != 0 && k == inj_at + 1) begin
          i_data_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int c = 1; c <= cycles; c++) begin
      @(negedge i_clk);
      check_vec(tag, c, {3'b000, 1'b0, last_par, 1'b0, 1'b0});
    end
  endtask

  initial begin
    // Reset state
    #1;
    check_vec("reset_async", 0, 7'b0);
    @(negedge i_clk);
    check_vec("reset_held", 1, 7'b0);
    i_rst = 1'b0;
    idle_check("post_reset", 2);

    // 0xA5 with even parity, N=1
    run_frame("a5_even_n1", 8'hA5, 1'b1, 1'b0, 1, 0, 0);
    // 0x00 odd parity, N=4, launched in the done cycle of the previous frame
    run_frame("00_odd_n4", 8'h00, 1'b1, 1'b1, 4, 0, 0);
    // 0xFF no parity, N=0 behaves as N=1, also back-to-back
    run_frame("ff_nopar_n0", 8'hFF, 1'b0, 1'b0, 0, 0, 0);
    idle_check("idle_after_ff", 3);

    // Valid and config changes mid-frame are ignored
    run_frame("81_busy_inj", 8'h81, 1'b1, 1'b0, 1, 5, 0);
    i_par_en = 1'b0; i_par_typ = 1'b0; i_clks_per_bit = 16'd1;
    idle_check("no_second_frame", 12);

    // Reset during the 3rd data bit (N=2: START 1-2, bit0 3-4, bit1 5-6, bit2 7-8)
    run_frame("5a_abort", 8'h5A, 1'b1, 1'b0, 2, 0, 7);
    for (int c = 1; c <= 3; c++) begin
      @(negedge i_clk);
      check_vec("abort_no_done", c, 7'b0);
    end
    i_rst = 1'b0;
    idle_check("abort_release", 2);
    run_frame("after_abort", 8'h3C, 1'b1, 1'b1, 3, 0, 0);

    // 0xA5, parity, N=2 (24-cycle frame when two stop bits are built in)
    run_frame("a5_even_n2", 8'hA5, 1'b1, 1'b0, 2, 0, 0);
    idle_check("final_idle", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. Accepts a parallel byte with a valid strobe, then steps the line through start, data, optional parity and stop bits at a programmable bit rate. Drives the 3-bit select of the downstream TX output mux plus the serial data and parity bits that the mux forwards. Sits between the host-side byte interface and the TX output mux.

Parameters:
DATA_WIDTH, 8, payload bits per frame.
PRESCALE_WIDTH, 16, width of the clocks-per-bit setting.
SEL_WIDTH, 3, width of the mux select output.

Ports:
i_clk  input  1  system clock, rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_p_data  input  DATA_WIDTH  parallel payload.
i_data_valid  input  1  payload valid strobe.
i_par_en  input  1  1 = parity bit inserted.
i_par_typ  input  1  0 = even parity, 1 = odd parity.
i_clks_per_bit  input  PRESCALE_WIDTH  clock cycles per bit period.
o_sel  output  SEL_WIDTH  mux select: 000 IDLE, 001 START, 010 DATA, 011 PARITY, 100 STOP.
o_ser_data  output  1  current data bit, LSB first.
o_parity_bit  output  1  computed parity bit.
o_busy  output  1  frame in progress.
o_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset is asynchronous and active-high. While i_rst is high: state = IDLE, o_sel = 000, o_ser_data = 0, o_parity_bit = 0, o_busy = 0, o_done = 0, all counters = 0.
- Reset mid-frame aborts immediately. o_sel returns to 000 without waiting for a clock edge. No o_done is issued.
- All outputs are registered. o_sel is the state encoding itself.
- Acceptance: on a rising edge in IDLE with i_data_valid = 1:
  - latch i_p_data into the shift register;
  - latch i_par_en, i_par_typ and i_clks_per_bit;
  - compute parity = ^data XOR i_par_typ;
  - move to START.
- i_data_valid outside IDLE is ignored. There is no queue and no error flag.
- Bit period: N = latched i_clks_per_bit; a value of 0 is treated as 1. A prescale counter counts 0..N-1. Each state except IDLE lasts exactly N cycles per bit.
- State transitions:
  - START, N cycles -> DATA.
  - DATA lasts DATA_WIDTH bit periods. o_ser_data = shift_reg[0]; the shift register shifts right at the end of each bit period. A bit counter counts 0..DATA_WIDTH-1.
  - At the end of the last data bit: go to PARITY if parity is enabled, else STOP.
  - PARITY, N cycles -> STOP.
  - STOP, N cycles -> IDLE. o_done pulses high for the first IDLE cycle.
- o_busy = 1 in every state other than IDLE.
- Minimum one IDLE cycle between frames. Valid asserted in that cycle is accepted.
- o_parity_bit holds its value from acceptance until the next acceptance.
- Changes to i_par_en, i_par_typ and i_clks_per_bit mid-frame have no effect on the current frame.
- Frame length in cycles = N × (1 + DATA_WIDTH + par_en + stop_bits), where stop_bits = 1 by default.

Optional Feature:
UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 bit periods (2N cycles), so stop_bits = 2. o_done still pulses once, after the second stop bit.
- Undefined: STOP lasts 1 bit period. No second-stop logic is synthesised.

Test Plan:
1. Reset, then valid with i_p_data = 0xA5, par_en = 1, par_typ = 0, clks_per_bit = 1.
   -> o_sel: 001 for 1 cycle, 010 for 8 cycles, 011 for 1 cycle, 100 for 1 cycle, then 000.
   -> o_ser_data sequence 1,0,1,0,0,1,0,1; o_parity_bit = 0.
   -> o_done pulses in cycle 12 after acceptance; o_busy high for exactly 11 cycles.
2. 0x00, par_en = 1, par_typ = 1, clks_per_bit = 4.
   -> o_parity_bit = 1; every o_sel value held 4 cycles; busy for 44 cycles.
3. 0xFF, par_en = 0, clks_per_bit = 0.
   -> treated as N = 1; state 011 never appears; busy for 10 cycles.
4. Pulse valid with 0x3C while busy, 5 cycles into a 0x81 frame.
   -> 0x81 completes unchanged; 0x3C is dropped; no second frame.
5. Assert i_rst during the 3rd data bit.
   -> o_sel = 000 and o_busy = 0 before the next edge; no o_done.
   -> After release, a new valid is accepted normally.
6. With UART_TX_TWO_STOP_EN defined, 0xA5, par_en = 1, N = 2.
   -> STOP held 4 cycles; frame lasts 24 cycles; a single o_done pulse.
